// File: rtl/serial_pattern_scheduler.sv
// serial_pattern_scheduler
//   Accepts a WIDTH-bit word, clears an external serial pattern detector,
//   streams the word to it MSB first, counts the detector's match flags
//   (saturating) and presents the count to a downstream consumer.
//
//   The four-state FSM (IDLE, CLEAR, SHIFT, DONE) runs one cycle ahead of
//   the pins: every output except in_ready is a register loaded from the
//   current state, so the detector sees det_clr/det_en/det_x one cycle after
//   the FSM enters the matching state. in_ready is loaded from the next state
//   so upstream never sees it high once a word has been taken.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   upstream word valid
//   in_data    in   [WIDTH] upstream word, serialized MSB first
//   in_ready   out  block can accept a word
//   abort      in   synchronous job cancel
//   det_clr    out  one-cycle detector clear request
//   det_en     out  det_x carries a valid serial bit
//   det_x      out  serial bit to the detector
//   det_y      in   detector match flag (used only while det_en=1)
//   out_valid  out  match count available
//   out_count  out  [CNT_W] matches found in the last word
//   out_ready  in   downstream accepts out_count
module serial_pattern_scheduler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             det_clr,
  output logic             det_en,
  output logic             det_x,
  input  logic             det_y,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_count,
  input  logic             out_ready
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             in_ready_q, in_ready_d;
  logic             det_clr_q, det_clr_d;
  logic             det_en_q, det_en_d;
  logic             det_x_q, det_x_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             hit_s;

  // Next-state, datapath and output-register inputs.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;

    // det_y is meaningful only in the cycles where det_en is on the pins;
    // the last bit's flag arrives while the FSM is already in DONE.
    hit_s = det_en_q && det_y;
    if (hit_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (abort) begin
      // Cancel wins in every state, including over a word offered in IDLE.
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d = CLEAR;
            shreg_d = in_data;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        CLEAR: begin
          state_d = SHIFT;
        end
        SHIFT: begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            idx_d   = '0;
          end else begin
            state_d = SHIFT;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          // Handshake on the visible out_valid, not on the state.
          if (out_valid_q && out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    in_ready_d  = (state_d == IDLE);
    det_clr_d   = (state_q == CLEAR) && (state_d == SHIFT);
    det_en_d    = (state_q == SHIFT) && (state_d != IDLE);
    det_x_d     = det_en_d ? shreg_q[WIDTH-1] : 1'b0;
    // Rises one cycle after DONE is entered (so the last flag is counted)
    // and drops on the same edge the FSM leaves DONE.
    out_valid_d = (state_q == DONE) && (state_d == DONE);
    out_count_d = cnt_d;
  end

  // FSM, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      det_clr_q   <= 1'b0;
      det_en_q    <= 1'b0;
      det_x_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      det_clr_q   <= det_clr_d;
      det_en_q    <= det_en_d;
      det_x_q     <= det_x_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign det_clr   = det_clr_q;
  assign det_en    = det_en_q;
  assign det_x     = det_x_q;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_serial_pattern_scheduler.sv
// Bench for serial_pattern_scheduler: pairs the block with a 101 overlapping
// Mealy detector and checks counts, serial order, latency, handshake, abort,
// asynchronous reset and counter saturation.
module tb_serial_pattern_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, abort, out_ready;
  logic [7:0] in_data;
  logic       in_ready, det_clr, det_en, det_x, det_y, out_valid;
  logic [3:0] out_count;

  logic       s_in_valid, s_out_ready;
  logic [7:0] s_in_data;
  logic       s_in_ready, s_det_clr, s_det_en, s_det_x, s_out_valid;
  logic [2:0] s_out_count;
  logic       s_abort = 1'b0;
  logic       s_det_y = 1'b1;

  logic [1:0] det_st;
  logic       y_idle_force = 1'b0;

  int         cyc;
  int         acc_edge;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [3:0] exp_q[$];
  logic [2:0] sat_q[$];

  serial_pattern_scheduler #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .abort(abort), .det_clr(det_clr), .det_en(det_en),
    .det_x(det_x), .det_y(det_y), .out_valid(out_valid),
    .out_count(out_count), .out_ready(out_ready)
  );

  serial_pattern_scheduler #(.WIDTH(8), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .abort(s_abort), .det_clr(s_det_clr),
    .det_en(s_det_en), .det_x(s_det_x), .det_y(s_det_y),
    .out_valid(s_out_valid), .out_count(s_out_count), .out_ready(s_out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 101 overlapping Mealy detector: 0 = start, 1 = seen 1, 2 = seen 10.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) det_st <= 2'd0;
    else if (det_clr) det_st <= 2'd0;
    else if (det_en) begin
      case (det_st)
        2'd0:    det_st <= det_x ? 2'd1 : 2'd0;
        2'd1:    det_st <= det_x ? 2'd1 : 2'd2;
        2'd2:    det_st <= det_x ? 2'd1 : 2'd0;
        default: det_st <= 2'd0;
      endcase
    end
  end

  assign det_y = (!det_en && y_idle_force) ? 1'b1 : ((det_st == 2'd2) && det_x);

  function automatic logic [3:0] ref_count(input logic [7:0] w);
    int st = 0;
    int n = 0;
    for (int i = 7; i >= 0; i--) begin
      if (st == 2 && w[i]) n++;
      if (w[i]) st = 1;
      else if (st == 1) st = 2;
      else st = 0;
    end
    return 4'(n);
  endfunction

  // Offer one word when in_ready, record its acceptance edge, push the expectation.
  task automatic send_word(input logic [7:0] w);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    in_valid = 1'b1;
    in_data  = w;
    exp_q.push_back(ref_count(w));
    acc_edge = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Observe the detector interface until out_valid (bounded); no checking here.
  task automatic collect(input int max_cyc, output bit got, output logic [3:0] cnt,
                         output int lat, output int clr_lat, output int en_first,
                         output logic [7:0] bits, output int nbits);
    got = 1'b0; cnt = 4'd0; lat = -1; clr_lat = -1; en_first = -1;
    bits = 8'd0; nbits = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      if (det_clr && clr_lat < 0) clr_lat = cyc - acc_edge;
      if (det_en) begin
        if (en_first < 0) en_first = cyc - acc_edge;
        bits = {bits[6:0], det_x};
        nbits++;
      end
      if (out_valid) begin
        got = 1'b1;
        cnt = out_count;
        lat = cyc - acc_edge;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; abort = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = 8'd0; s_out_ready = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, det_clr, det_en, det_x, out_valid, out_count} !== 9'b1_0000_0000)
      $display("FAIL reset_during got=%b want=100000000",
               {in_ready, det_clr, det_en, det_x, out_valid, out_count});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({in_ready, det_clr, det_en, det_x, out_valid, out_count} !== 9'b1_0000_0000)
      $display("FAIL reset_after got=%b want=100000000",
               {in_ready, det_clr, det_en, det_x, out_valid, out_count});
    else pass_cnt++;
    total_cnt++;
    if ({s_in_ready, s_det_clr, s_det_en, s_det_x, s_out_valid, s_out_count} !== 8'b1_0000_000)
      $display("FAIL reset_sat got=%b want=10000000",
               {s_in_ready, s_det_clr, s_det_en, s_det_x, s_out_valid, s_out_count});
    else pass_cnt++;
  endtask

  task automatic test_a5_latency();
    bit got; logic [3:0] cnt, exp; int lat, clr_lat, en_first, nbits; logic [7:0] bits;
    out_ready = 1'b1;
    send_word(8'hA5);
    collect(30, got, cnt, lat, clr_lat, en_first, bits, nbits);
    exp = exp_q.pop_front();
    total_cnt++;
    if (!got || cnt !== exp || exp !== 4'd2) $display("FAIL a5_count got=%0d want=2", cnt);
    else pass_cnt++;
    total_cnt++;
    if (bits !== 8'hA5 || nbits != 8) $display("FAIL a5_bits got=%b/%0d want=10100101/8", bits, nbits);
    else pass_cnt++;
    total_cnt++;
    if (lat != 10 || clr_lat != 1 || en_first != 2)
      $display("FAIL a5_latency got valid=%0d clr=%0d en=%0d want 10/1/2", lat, clr_lat, en_first);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL a5_release got valid=%b ready=%b want 0/1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_patterns();
    logic [7:0] words[4] = '{8'h55, 8'hFF, 8'h00, 8'hB6};
    bit got; logic [3:0] cnt, exp; int lat, clr_lat, en_first, nbits; logic [7:0] bits;
    out_ready = 1'b1;
    foreach (words[i]) begin
      send_word(words[i]);
      collect(30, got, cnt, lat, clr_lat, en_first, bits, nbits);
      exp = exp_q.pop_front();
      total_cnt++;
      if (!got || cnt !== exp)
        $display("FAIL pattern_%h got=%0d want=%0d", words[i], cnt, exp);
      else pass_cnt++;
      total_cnt++;
      if (bits !== words[i]) $display("FAIL pattern_bits_%h got=%b", words[i], bits);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[3] = '{8'hA5, 8'h55, 8'h00};
    bit got; logic [3:0] cnt, exp; int lat, clr_lat, en_first, nbits, extra; logic [7:0] bits;
    out_ready = 1'b1;
    foreach (words[i]) begin
      send_word(words[i]);
      collect(30, got, cnt, lat, clr_lat, en_first, bits, nbits);
      exp = exp_q.pop_front();
      total_cnt++;
      if (!got || cnt !== exp || in_ready !== 1'b0)
        $display("FAIL b2b_%0d got=%0d ready=%b want=%0d ready=0", i, cnt, in_ready, exp);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL b2b_once_%0d got valid=%b want 0", i, out_valid);
      else pass_cnt++;
    end
    extra = 0;
    repeat (5) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    total_cnt++;
    if (extra != 0) $display("FAIL b2b_dup got=%0d extra pulses want=0", extra);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    bit got; logic [3:0] cnt, exp; int lat, clr_lat, en_first, nbits; logic [7:0] bits;
    out_ready = 1'b0;
    send_word(8'h55);
    in_valid = 1'b1;
    in_data  = 8'h00;
    collect(30, got, cnt, lat, clr_lat, en_first, bits, nbits);
    exp = exp_q.pop_front();
    total_cnt++;
    if (!got || cnt !== exp || bits !== 8'h55)
      $display("FAIL hold_word got=%0d bits=%b want=%0d 01010101", cnt, bits, exp);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      total_cnt++;
      if ({out_valid, in_ready, out_count} !== {1'b1, 1'b0, exp})
        $display("FAIL hold_stable_%0d got=%b want=%b", i,
                 {out_valid, in_ready, out_count}, {1'b1, 1'b0, exp});
      else pass_cnt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL hold_release got=%b want=01", {out_valid, in_ready});
    else pass_cnt++;
  endtask

  task automatic test_abort();
    bit got; logic [3:0] cnt, exp; int lat, clr_lat, en_first, nbits, en_seen, bad;
    logic [7:0] bits;
    out_ready = 1'b1;
    send_word(8'hA5);
    en_seen = 0;
    for (int i = 0; i < 20 && en_seen < 4; i++) begin
      if (det_en) en_seen++;
      if (en_seen < 4) @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    void'(exp_q.pop_front());
    total_cnt++;
    if ({det_en, det_x, in_ready, out_valid} !== 4'b0010)
      $display("FAIL abort_shift got=%b want=0010", {det_en, det_x, in_ready, out_valid});
    else pass_cnt++;
    bad = 0;
    repeat (15) begin
      if (out_valid) bad++;
      @(negedge clk);
    end
    total_cnt++;
    if (bad != 0) $display("FAIL abort_no_valid got=%0d pulses want=0", bad);
    else pass_cnt++;
    // Abort and a word offered together in IDLE: nothing is captured.
    abort = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    bad = 0;
    repeat (4) begin
      if (!in_ready || det_clr || det_en) bad++;
      @(negedge clk);
    end
    total_cnt++;
    if (bad != 0) $display("FAIL abort_idle got=%0d busy cycles want=0", bad);
    else pass_cnt++;
    send_word(8'h55);
    collect(30, got, cnt, lat, clr_lat, en_first, bits, nbits);
    exp = exp_q.pop_front();
    total_cnt++;
    if (!got || cnt !== exp || exp !== 4'd3) $display("FAIL abort_next got=%0d want=3", cnt);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got; logic [3:0] cnt, exp; int lat, clr_lat, en_first, nbits, en_seen; logic [7:0] bits;
    out_ready = 1'b1;
    send_word(8'hA5);
    en_seen = 0;
    for (int i = 0; i < 20 && en_seen < 3; i++) begin
      if (det_en) en_seen++;
      if (en_seen < 3) @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    void'(exp_q.pop_front());
    total_cnt++;
    if ({in_ready, det_clr, det_en, det_x, out_valid, out_count} !== 9'b1_0000_0000)
      $display("FAIL reset_async got=%b want=100000000",
               {in_ready, det_clr, det_en, det_x, out_valid, out_count});
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_word(8'hA5);
    collect(30, got, cnt, lat, clr_lat, en_first, bits, nbits);
    exp = exp_q.pop_front();
    total_cnt++;
    if (!got || cnt !== exp || lat != 10) $display("FAIL reset_resume got=%0d lat=%0d want=2 lat=10", cnt, lat);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_ignore_y();
    logic [7:0] words[2] = '{8'h00, 8'h01};
    bit got; logic [3:0] cnt, exp; int lat, clr_lat, en_first, nbits; logic [7:0] bits;
    out_ready = 1'b1;
    y_idle_force = 1'b1;
    repeat (3) @(negedge clk);
    foreach (words[i]) begin
      send_word(words[i]);
      collect(30, got, cnt, lat, clr_lat, en_first, bits, nbits);
      exp = exp_q.pop_front();
      total_cnt++;
      if (!got || cnt !== exp) $display("FAIL ignore_y_%h got=%0d want=%0d", words[i], cnt, exp);
      else pass_cnt++;
      @(negedge clk);
    end
    y_idle_force = 1'b0;
  endtask

  task automatic test_saturate();
    bit got; int nclr, nen; logic [7:0] bits; logic [2:0] cnt;
    total_cnt++;
    if (s_in_ready !== 1'b1) $display("FAIL sat_ready got=%b want=1", s_in_ready);
    else pass_cnt++;
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_data   = 8'hA5;
    sat_q.push_back(3'd7);
    @(negedge clk);
    s_in_valid = 1'b0;
    got = 1'b0; nclr = 0; nen = 0; bits = 8'd0; cnt = 3'd0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (s_det_clr) nclr++;
      if (s_det_en) begin
        nen++;
        bits = {bits[6:0], s_det_x};
      end
      if (s_out_valid) begin
        got = 1'b1;
        cnt = s_out_count;
      end else begin
        @(negedge clk);
      end
    end
    total_cnt++;
    if (!got || cnt !== sat_q.pop_front()) $display("FAIL sat_count got=%0d want=7", cnt);
    else pass_cnt++;
    total_cnt++;
    if (nclr != 1 || nen != 8 || bits !== 8'hA5)
      $display("FAIL sat_stream got clr=%0d en=%0d bits=%b want 1/8/10100101", nclr, nen, bits);
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_a5_latency();
    test_patterns();
    test_back_to_back();
    test_hold();
    test_abort();
    test_reset_mid();
    test_ignore_y();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
